// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// The master drives the upstream offer, downstream ready and flush; the slave is the stage itself.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy, stall_cycles
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy, stall_cycles
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: main entry plus one skid entry, synchronous flush to a
// zero bubble, and a saturating stall-cycle counter for performance debug.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_skid_if.slave  bus
);

  // Initialisers match the reset state so simulation without a reset pulse starts clean.
  logic              main_valid_q = 1'b0;
  logic              skid_valid_q = 1'b0;
  logic [DATA_W-1:0] main_data_q  = '0;
  logic [DATA_W-1:0] skid_data_q  = '0;
  logic [CNT_W-1:0]  stall_q      = '0;

  logic              main_valid_d;
  logic              skid_valid_d;
  logic [DATA_W-1:0] main_data_d;
  logic [DATA_W-1:0] skid_data_d;
  logic [CNT_W-1:0]  stall_d;

  logic in_fire;
  logic out_fire;
  logic stalled;

  // in_ready comes straight from the skid register, so out_ready never reaches it combinationally.
  assign in_fire  = bus.in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & bus.out_ready;
  assign stalled  = main_valid_q & ~bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = '0;
      skid_data_d  = '0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = bus.in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = bus.in_data;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
    end
  end

  // Counter saturates at all-ones; flush does not touch it.
  always_comb begin
    stall_d = stall_q;
    if (stalled && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      stall_q      <= stall_d;
    end
  end

  // main_data_q is zeroed whenever main_valid_q drops, so out_data needs no gating.
  assign bus.in_ready     = ~skid_valid_q;
  assign bus.out_valid    = main_valid_q;
  assign bus.out_data     = main_data_q;
  assign bus.occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard checks for pipe_stage_skid, plus a narrow-counter instance for saturation.
module tb_pipe_stage_skid;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) bus_a ();
  pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(3))  bus_b ();

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(3)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0; bus_b.flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus_a.out_valid, bus_a.in_ready, bus_a.occupancy} !== 4'b0100) begin
      errors++; $display("FAIL reset_ctl got v=%0b r=%0b occ=%0d want v=0 r=1 occ=0",
                         bus_a.out_valid, bus_a.in_ready, bus_a.occupancy);
    end
    checks++;
    if (bus_a.out_data !== '0 || bus_a.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_data got data=%h stall=%0d want 0 0", bus_a.out_data, bus_a.stall_cycles);
    end
    $display("reset: out_valid=%0b in_ready=%0b occ=%0d", bus_a.out_valid, bus_a.in_ready, bus_a.occupancy);
  endtask

  task automatic test_stream;
    logic [DW-1:0] vals [3];
    vals[0] = 'h11; vals[1] = 'h22; vals[2] = 'h33;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = vals[i];
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== vals[i] || bus_a.occupancy !== 2'd1) begin
        errors++; $display("FAIL stream_%0d got v=%0b data=%h occ=%0d want v=1 data=%h occ=1",
                           i, bus_a.out_valid, bus_a.out_data, bus_a.occupancy, vals[i]);
      end
      $display("stream: push %h -> out %h", vals[i], bus_a.out_data);
    end
    bus_a.in_valid = 1'b0;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== '0 || bus_a.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL stream_drain got v=%0b data=%h stall=%0d want 0 0 0",
                         bus_a.out_valid, bus_a.out_data, bus_a.stall_cycles);
    end
  endtask

  task automatic test_skid_stall;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 'hA1;
    tick();
    bus_a.in_data = 'hA2;
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.occupancy !== 2'd2 || bus_a.in_ready !== 1'b0) begin
      errors++; $display("FAIL skid_full got occ=%0d in_ready=%0b want occ=2 in_ready=0",
                         bus_a.occupancy, bus_a.in_ready);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus_a.out_data !== 'hA1 || bus_a.stall_cycles !== 16'd6) begin
      errors++; $display("FAIL skid_hold got data=%h stall=%0d want a1 6", bus_a.out_data, bus_a.stall_cycles);
    end
    bus_a.out_ready = 1'b1;
    tick();
    checks++;
    if (bus_a.out_data !== 'hA2 || bus_a.in_ready !== 1'b1 || bus_a.occupancy !== 2'd1) begin
      errors++; $display("FAIL skid_drain1 got data=%h in_ready=%0b occ=%0d want a2 1 1",
                         bus_a.out_data, bus_a.in_ready, bus_a.occupancy);
    end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.stall_cycles !== 16'd6) begin
      errors++; $display("FAIL skid_drain2 got v=%0b stall=%0d want 0 6", bus_a.out_valid, bus_a.stall_cycles);
    end
    $display("skid: stall_cycles=%0d after release", bus_a.stall_cycles);
  endtask

  task automatic test_flush;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 'hB1;
    tick();
    bus_a.in_data = 'hB2;
    tick();
    bus_a.in_data = 'hB3; bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0; bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== '0 || bus_a.occupancy !== 2'd0) begin
      errors++; $display("FAIL flush_full got v=%0b data=%h occ=%0d want 0 0 0",
                         bus_a.out_valid, bus_a.out_data, bus_a.occupancy);
    end
    checks++;
    if (bus_a.stall_cycles !== 16'd8) begin
      errors++; $display("FAIL flush_stall got %0d want 8", bus_a.stall_cycles);
    end
    bus_a.out_ready = 1'b1;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_b3 got v=%0b data=%h want v=0", bus_a.out_valid, bus_a.out_data);
    end
    // empty stage: in_fire coinciding with flush is accepted then discarded
    bus_a.in_valid = 1'b1; bus_a.in_data = 'hB4; bus_a.flush = 1'b1;
    tick();
    bus_a.in_valid = 1'b0; bus_a.flush = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_fire got v=%0b in_ready=%0b want 0 1", bus_a.out_valid, bus_a.in_ready);
    end
    $display("flush: occ=%0d stall=%0d", bus_a.occupancy, bus_a.stall_cycles);
  endtask

  task automatic test_mid_reset;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 'hC8;
    tick();
    bus_a.in_data = 'hC9;
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.occupancy !== 2'd2 || bus_a.stall_cycles !== 16'd9) begin
      errors++; $display("FAIL pre_reset got occ=%0d stall=%0d want 2 9", bus_a.occupancy, bus_a.stall_cycles);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== '0 || bus_a.occupancy !== 2'd0 ||
        bus_a.stall_cycles !== 16'd0 || bus_a.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%0b data=%h occ=%0d stall=%0d rdy=%0b want 0 0 0 0 1",
                         bus_a.out_valid, bus_a.out_data, bus_a.occupancy, bus_a.stall_cycles, bus_a.in_ready);
    end
    bus_a.out_ready = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = 'hC1;
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 'hC1) begin
      errors++; $display("FAIL post_reset got v=%0b data=%h want 1 c1", bus_a.out_valid, bus_a.out_data);
    end
    tick();
    $display("mid_reset: recovered, pushed c1");
  endtask

  task automatic test_saturation;
    bus_b.out_ready = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.in_data = 'h5;
    tick();
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus_b.stall_cycles !== 3'd6) begin
      errors++; $display("FAIL sat_6 got %0d want 6", bus_b.stall_cycles);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus_b.stall_cycles !== 3'd7 || bus_b.out_data !== 'h5) begin
      errors++; $display("FAIL sat_10 got stall=%0d data=%h want 7 5", bus_b.stall_cycles, bus_b.out_data);
    end
    $display("saturation: stall_cycles=%0d after 10 stalled cycles", bus_b.stall_cycles);
  endtask

  task automatic test_random;
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_data;
    logic          iv, ordy;
    int            delivered = 0;
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      bus_a.in_valid  = iv;
      bus_a.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus_a.out_ready = ordy;
      exp_data = (q.size() > 0) ? q[0] : '0;
      checks++;
      if (bus_a.occupancy !== 2'(q.size()) || bus_a.in_ready !== (q.size() < 2) ||
          bus_a.out_valid !== (q.size() > 0)) begin
        errors++;
        if (errors < 20) $display("FAIL rand_ctl cyc %0d got occ=%0d rdy=%0b v=%0b want occ=%0d",
                                  c, bus_a.occupancy, bus_a.in_ready, bus_a.out_valid, q.size());
      end
      checks++;
      if (bus_a.out_data !== exp_data) begin
        errors++;
        if (errors < 20) $display("FAIL rand_data cyc %0d got %h want %h", c, bus_a.out_data, exp_data);
      end
      if (q.size() > 0 && ordy) begin
        void'(q.pop_front());
        delivered++;
      end
      if (iv && q.size() < 2 + ((q.size() >= 0) ? 0 : 0) && bus_a.in_ready === 1'b1) q.push_back(bus_a.in_data);
      tick();
    end
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    $display("random: %0d transfers delivered", delivered);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_stall();
    test_flush();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
